// File: rtl/crc_pkg.sv
// Shared definitions for the CRC frame serializer: FSM states, error codes
// and default parameter values.
package crc_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_CRC_WIDTH  = 8;
   localparam int DEF_MAX_WORDS  = 16;
   localparam int DEF_TIMEOUT    = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT    = 2'd1,
      WAIT_CRC = 2'd2,
      CAPTURE  = 2'd3
   } state_t;

   localparam logic [1:0] UNDERRUN = 2'b01;
   localparam logic [1:0] LEN_OVF  = 2'b10;
   localparam logic [1:0] CRC_TMO  = 2'b11;

endpackage

// File: rtl/crc_bit_collector.sv
// Serial-to-parallel collector for the CRC bits returned by the engine.
// Bits enter at the MSB and shift right, so the first bit lands in bit 0.
// done flags the edge on which the final bit arrives. dropout flags that
// Valid fell while a capture was in progress.
module crc_bit_collector
   import crc_pkg::*;
#(
   parameter int CRC_WIDTH = DEF_CRC_WIDTH
)(
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 clear,
   input  logic                 shift_en,
   input  logic                 armed,
   input  logic                 bit_in,
   output logic [CRC_WIDTH-1:0] cap_next,
   output logic                 done,
   output logic                 dropout
);

   localparam int CNT_W = $clog2(CRC_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CRC_WIDTH);

   logic [CRC_WIDTH-1:0] cap_q, cap_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   // Next capture value and count, with the count saturating at CRC_WIDTH
   always_comb begin
      cap_next = {bit_in, cap_q[CRC_WIDTH-1:1]};
      done     = shift_en && (cnt_q == CNT_LAST);
      dropout  = armed && !shift_en;
      cap_d    = cap_q;
      cnt_d    = cnt_q;
      if (clear) begin
         cap_d = '0;
         cnt_d = '0;
      end else if (shift_en) begin
         cap_d = cap_next;
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Capture registers with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RST) begin
         cap_q <= '0;
         cnt_q <= '0;
      end else begin
         cap_q <= cap_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/crc_frame_serializer.sv
// Feeder/collector for a serial CRC-8 engine. Accepts parallel words over
// valid/ready, sends them LSB-first on SER_DATA framed by ACTIVE, then
// gathers the engine's serial CRC into CRC_OUT. Status comes out as
// one-cycle CRC_DONE and ERR pulses.
module crc_frame_serializer
   import crc_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CRC_WIDTH  = DEF_CRC_WIDTH,
   parameter int MAX_WORDS  = DEF_MAX_WORDS,
   parameter int TIMEOUT    = DEF_TIMEOUT
)(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  P_VALID,
   input  logic                  P_LAST,
   output logic                  P_READY,
   output logic                  SER_DATA,
   output logic                  ACTIVE,
   input  logic                  CRC_IN,
   input  logic                  CRC_VLD,
   output logic [CRC_WIDTH-1:0]  CRC_OUT,
   output logic                  CRC_DONE,
   output logic                  ERR,
   output logic [1:0]            ERR_CODE
);

   localparam int BCW = $clog2(DATA_WIDTH);
   localparam int WCW = $clog2(MAX_WORDS + 1);
   localparam int TCW = $clog2(TIMEOUT + 1);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);
   localparam logic [WCW-1:0] WORD_MAX = WCW'(MAX_WORDS);
   localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT - 1);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [WCW-1:0]        word_cnt_q, word_cnt_d;
   logic [TCW-1:0]        tmo_cnt_q, tmo_cnt_d;
   logic                  last_q, last_d;
   logic                  ser_q, ser_d;
   logic                  active_q, active_d;
   logic [CRC_WIDTH-1:0]  crc_out_q, crc_out_d;
   logic                  crc_done_q, crc_done_d;
   logic                  err_q, err_d;
   logic [1:0]            err_code_q, err_code_d;

   logic                  col_shift;
   logic [CRC_WIDTH-1:0]  col_cap_next;
   logic                  col_done;
   logic                  col_dropout;

   // Ready is the only combinational output: open in IDLE and on the final
   // bit of a non-last word, unless the frame has hit its word limit
   assign P_READY = (state_q == IDLE) ||
                    ((state_q == SHIFT) && (bit_cnt_q == BIT_LAST) &&
                     !last_q && (word_cnt_q != WORD_MAX));

   assign col_shift = CRC_VLD && ((state_q == WAIT_CRC) || (state_q == CAPTURE));

   crc_bit_collector #(
      .CRC_WIDTH (CRC_WIDTH)
   ) u_collector (
      .CLK      (CLK),
      .RST      (RST),
      .clear    (state_q == IDLE),
      .shift_en (col_shift),
      .armed    (state_q == CAPTURE),
      .bit_in   (CRC_IN),
      .cap_next (col_cap_next),
      .done     (col_done),
      .dropout  (col_dropout)
   );

   // Next-state and next-output decode for the frame FSM
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      last_d     = last_q;
      ser_d      = ser_q;
      active_d   = active_q;
      crc_out_d  = crc_out_q;
      crc_done_d = 1'b0;
      err_d      = 1'b0;
      err_code_d = err_code_q;

      unique case (state_q)
         IDLE: begin
            tmo_cnt_d = '0;
            if (P_VALID) begin
               shift_d    = P_DATA;
               ser_d      = P_DATA[0];
               active_d   = 1'b1;
               last_d     = P_LAST;
               word_cnt_d = WCW'(1);
               bit_cnt_d  = '0;
               state_d    = SHIFT;
            end
         end

         SHIFT: begin
            if (bit_cnt_q != BIT_LAST) begin
               shift_d   = shift_q >> 1;
               ser_d     = shift_d[0];
               bit_cnt_d = bit_cnt_q + 1'b1;
            end else if (!last_q && (word_cnt_q != WORD_MAX) && P_VALID) begin
               shift_d   = P_DATA;
               ser_d     = P_DATA[0];
               last_d    = P_LAST;
               bit_cnt_d = '0;
               if (word_cnt_q != WORD_MAX) begin
                  word_cnt_d = word_cnt_q + 1'b1;
               end
            end else begin
               active_d  = 1'b0;
               ser_d     = 1'b0;
               tmo_cnt_d = '0;
               state_d   = WAIT_CRC;
               if (!last_q) begin
                  err_d      = 1'b1;
                  err_code_d = (word_cnt_q == WORD_MAX) ? LEN_OVF : UNDERRUN;
               end
            end
         end

         WAIT_CRC: begin
            if (CRC_VLD) begin
               if (col_done) begin
                  crc_out_d  = col_cap_next;
                  crc_done_d = 1'b1;
                  state_d    = IDLE;
               end else begin
                  state_d = CAPTURE;
               end
            end else if (tmo_cnt_q == TMO_LAST) begin
               err_d      = 1'b1;
               err_code_d = CRC_TMO;
               state_d    = IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end

         CAPTURE: begin
            if (col_done) begin
               crc_out_d  = col_cap_next;
               crc_done_d = 1'b1;
               state_d    = IDLE;
            end else if (col_dropout) begin
               err_d      = 1'b1;
               err_code_d = CRC_TMO;
               state_d    = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Frame FSM registers, all outputs registered, synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         tmo_cnt_q  <= '0;
         last_q     <= 1'b0;
         ser_q      <= 1'b0;
         active_q   <= 1'b0;
         crc_out_q  <= '0;
         crc_done_q <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= '0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         last_q     <= last_d;
         ser_q      <= ser_d;
         active_q   <= active_d;
         crc_out_q  <= crc_out_d;
         crc_done_q <= crc_done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   assign SER_DATA = ser_q;
   assign ACTIVE   = active_q;
   assign CRC_OUT  = crc_out_q;
   assign CRC_DONE = crc_done_q;
   assign ERR      = err_q;
   assign ERR_CODE = err_code_q;

endmodule
